// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: issue/slot/completion signals between the ALU dispatch scheduler and its environment
//   master: drives rdy, flush, in_valid, in_needs_tag, slot_busy, done_valid, done_tag
//   slave : drives in_ready, en, alloc_tag, free_cnt, stall_cnt
interface alu_dispatch_if #(
    parameter int SLOTS = 2,
    parameter int TAG_W = 4
);
    logic                     rdy;
    logic                     flush;
    logic                     in_valid;
    logic                     in_needs_tag;
    logic                     in_ready;
    logic [SLOTS-1:0]         slot_busy;
    logic [SLOTS-1:0]         done_valid;
    logic [SLOTS*TAG_W-1:0]   done_tag;
    logic [SLOTS-1:0]         en;
    logic [TAG_W-1:0]         alloc_tag;
    logic [TAG_W-1:0]         free_cnt;
    logic [15:0]              stall_cnt;

    modport master (
        output rdy, flush, in_valid, in_needs_tag, slot_busy, done_valid, done_tag,
        input  in_ready, en, alloc_tag, free_cnt, stall_cnt
    );

    modport slave (
        input  rdy, flush, in_valid, in_needs_tag, slot_busy, done_valid, done_tag,
        output in_ready, en, alloc_tag, free_cnt, stall_cnt
    );
endinterface

// File: rtl/alu_dispatch_sched.sv
// alu_dispatch_sched: round-robin ALU RS slot issue with renaming-tag pool allocation
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : rdy/flush control, in_valid/in_needs_tag/in_ready issue handshake,
//                     slot_busy, done_valid/done_tag completion broadcast,
//                     en/alloc_tag registered issue outputs, free_cnt, stall_cnt
module alu_dispatch_sched #(
    parameter int SLOTS = 2,
    parameter int TAG_W = 4
) (
    input logic           clk,
    input logic           rst,
    alu_dispatch_if.slave bus
);
    localparam int NT = (1 << TAG_W) - 1;
    localparam int PW = SLOTS > 1 ? $clog2(SLOTS) : 1;
    localparam logic [TAG_W-1:0] UNL = '1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state, state_nx;
    logic [NT-1:0]    free_map, rel_mask, alloc_mask, map_nx;
    logic [SLOTS-1:0] pending, slot_free, sel_oh;
    logic [PW-1:0]    rr_ptr, sel_idx;
    logic [TAG_W-1:0] tag_sel, cnt_nx;
    logic             slot_any, tag_any, in_ready, issue, take_tag, stall;

    // pending masks a slot for the cycle between issue and its RS busy flag rising
    assign slot_free = ~bus.slot_busy & ~pending;
    assign sel_oh    = SLOTS'(1) << sel_idx;

    // Round-robin search: scan offsets high to low so the smallest offset from rr_ptr wins
    always_comb begin
        logic [PW-1:0] idx;
        sel_idx  = '0;
        slot_any = 1'b0;
        idx      = '0;
        for (int j = SLOTS - 1; j >= 0; j--) begin
            idx = PW'((int'(rr_ptr) + j) % SLOTS);
            if (slot_free[idx]) begin
                sel_idx  = idx;
                slot_any = 1'b1;
            end
        end
    end

    // Lowest-index free tag
    always_comb begin
        tag_sel = UNL;
        tag_any = 1'b0;
        for (int t = NT - 1; t >= 0; t--) begin
            if (free_map[t]) begin
                tag_sel = TAG_W'(t);
                tag_any = 1'b1;
            end
        end
    end

    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (bus.done_valid[i] && bus.done_tag[i*TAG_W +: TAG_W] != UNL)
                rel_mask[bus.done_tag[i*TAG_W +: TAG_W]] = 1'b1;
        end
    end

    // Release is applied before allocation clears: an allocated tag was already free,
    // so a same-cycle release of it is the ignored "already free" case
    assign alloc_mask = take_tag ? (NT'(1) << tag_sel) : '0;
    assign map_nx     = (free_map | rel_mask) & ~alloc_mask;

    always_comb begin
        cnt_nx = '0;
        for (int t = 0; t < NT; t++)
            cnt_nx = cnt_nx + TAG_W'(map_nx[t]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.rdy)
            state_nx = (state == RUN && bus.flush) ? FLUSH : RUN;
    end

    always_comb begin
        in_ready = bus.rdy & ~rst & (state == RUN) & ~bus.flush & slot_any
                 & (tag_any | ~bus.in_needs_tag);
        issue    = bus.in_valid & in_ready;
        take_tag = issue & bus.in_needs_tag;
        stall    = bus.in_valid & ~in_ready & bus.rdy;
    end

    assign bus.in_ready = in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            free_map      <= '1;
            bus.free_cnt  <= TAG_W'(NT);
            rr_ptr        <= '0;
            pending       <= '0;
            bus.stall_cnt <= '0;
            bus.en        <= '0;
            bus.alloc_tag <= UNL;
        end else if (!bus.rdy) begin
            bus.en        <= '0;
            bus.alloc_tag <= UNL;
        end else begin
            if (stall && bus.stall_cnt != 16'hFFFF)
                bus.stall_cnt <= bus.stall_cnt + 16'd1;
            if (bus.flush) begin
                free_map      <= '1;
                bus.free_cnt  <= TAG_W'(NT);
                pending       <= '0;
                bus.en        <= '0;
                bus.alloc_tag <= UNL;
            end else begin
                free_map      <= map_nx;
                bus.free_cnt  <= cnt_nx;
                pending       <= issue ? sel_oh : '0;
                bus.en        <= issue ? sel_oh : '0;
                bus.alloc_tag <= take_tag ? tag_sel : UNL;
                if (issue)
                    rr_ptr <= PW'((int'(sel_idx) + 1) % SLOTS);
            end
        end
    end
endmodule

// File: tb/tb_alu_dispatch_sched.sv
// tb_alu_dispatch_sched: directed and randomized checks of alu_dispatch_sched against a behavioural model
module tb_alu_dispatch_sched;
    logic clk, rst;
    int   total, bad;

    alu_dispatch_if #(.SLOTS(2), .TAG_W(4)) bus ();

    alu_dispatch_sched #(.SLOTS(2), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit mfree[15];
    bit mpend[2];
    bit mfl;
    int mrr, men, mtag, mcnt, mstall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit r, input bit f, input bit v, input bit n,
                          input logic [1:0] b, input logic [1:0] dv, input logic [7:0] dt);
        bus.rdy = r; bus.flush = f; bus.in_valid = v; bus.in_needs_tag = n;
        bus.slot_busy = b; bus.done_valid = dv; bus.done_tag = dt;
    endtask

    // One clock: check the combinational handshake, advance the model, check registered outputs
    task automatic cycle();
        int  k, t, tg;
        bit  ready;
        #1;
        k = -1;
        for (int j = 0; j < 2; j++) begin
            int idx = (mrr + j) % 2;
            if (k < 0 && !bus.slot_busy[idx] && !mpend[idx]) k = idx;
        end
        t = -1;
        for (int i = 14; i >= 0; i--) if (mfree[i]) t = i;
        ready = bus.rdy && !rst && !mfl && !bus.flush && k >= 0 && (t >= 0 || !bus.in_needs_tag);
        chk("in_ready", bus.in_ready, ready);
        if (rst) begin
            foreach (mfree[i]) mfree[i] = 1;
            mpend = '{0, 0}; mfl = 0; mrr = 0; men = 0; mtag = 15; mstall = 0;
        end else if (!bus.rdy) begin
            men = 0; mtag = 15;
        end else begin
            if (bus.in_valid && !ready && mstall < 65535) mstall++;
            men = 0; mtag = 15; mpend = '{0, 0};
            if (bus.flush) begin
                foreach (mfree[i]) mfree[i] = 1;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    tg = int'(bus.done_tag[i*4 +: 4]);
                    if (bus.done_valid[i] && tg != 15) mfree[tg] = 1;
                end
                if (bus.in_valid && ready) begin
                    men = 1 << k; mpend[k] = 1; mrr = (k + 1) % 2;
                    if (bus.in_needs_tag) begin mtag = t; mfree[t] = 0; end
                end
            end
            mfl = !mfl && bus.flush;
        end
        mcnt = 0;
        foreach (mfree[i]) mcnt += int'(mfree[i]);
        @(posedge clk);
        #1;
        chk("en", bus.en, men);
        chk("alloc_tag", bus.alloc_tag, mtag);
        chk("free_cnt", bus.free_cnt, mcnt);
        chk("stall_cnt", bus.stall_cnt, mstall);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1;
        set_in(1, 0, 0, 0, 2'b00, 2'b00, 8'hFF);
        cycle(); cycle();
        chk("rst_free_cnt", bus.free_cnt, 15);
        chk("rst_alloc_tag", bus.alloc_tag, 15);
        chk("rst_en", bus.en, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        rst = 0;

        // Three back-to-back accepts alternate slots and take tags 0,1,2
        set_in(1, 0, 1, 1, 2'b00, 2'b00, 8'hFF);
        cycle(); chk("t1_en0", bus.en, 1); chk("t1_tag0", bus.alloc_tag, 0);
        cycle(); chk("t1_en1", bus.en, 2); chk("t1_tag1", bus.alloc_tag, 1);
        cycle(); chk("t1_en2", bus.en, 1); chk("t1_tag2", bus.alloc_tag, 2);
        chk("t1_free", bus.free_cnt, 12);
        cycle(); chk("t1_en3", bus.en, 2);

        // Both slots busy stalls; freeing slot 1 picks it although rr_ptr points at 0
        set_in(1, 0, 1, 1, 2'b11, 2'b00, 8'hFF);
        repeat (3) cycle();
        chk("t2_stall", bus.stall_cnt, 3);
        set_in(1, 0, 1, 1, 2'b01, 2'b00, 8'hFF);
        cycle(); chk("t2_en", bus.en, 2); chk("t2_tag", bus.alloc_tag, 4);

        // Exhaust the pool, then tagless issue still proceeds
        set_in(1, 0, 1, 1, 2'b00, 2'b00, 8'hFF);
        for (int i = 0; i < 40 && mcnt > 0; i++) cycle();
        chk("t3_empty", bus.free_cnt, 0);
        cycle();
        set_in(1, 0, 1, 0, 2'b00, 2'b00, 8'hFF);
        #1 chk("t3_notag_ready", bus.in_ready, 1);
        cycle(); chk("t3_notag_tag", bus.alloc_tag, 15);
        set_in(1, 0, 0, 1, 2'b00, 2'b01, 8'hF7);
        cycle();
        set_in(1, 0, 1, 1, 2'b00, 2'b00, 8'hFF);
        cycle(); chk("t3_tag7", bus.alloc_tag, 7);

        // Release of tag 3 is not visible the same cycle; a second release is ignored
        set_in(1, 0, 1, 1, 2'b00, 2'b01, 8'hF3);
        #1 chk("t4_no_bypass", bus.in_ready, 0);
        cycle(); chk("t4_free", bus.free_cnt, 1);
        set_in(1, 0, 0, 1, 2'b00, 2'b10, 8'h3F);
        cycle(); chk("t4_double", bus.free_cnt, 1);
        set_in(1, 0, 1, 1, 2'b00, 2'b00, 8'hFF);
        cycle(); chk("t4_tag3", bus.alloc_tag, 3);

        // Flush frees everything, blocks one cycle, then allocation restarts at tag 0
        set_in(1, 1, 1, 1, 2'b00, 2'b00, 8'hFF);
        cycle(); chk("t5_en", bus.en, 0); chk("t5_free", bus.free_cnt, 15);
        set_in(1, 0, 1, 1, 2'b00, 2'b00, 8'hFF);
        #1 chk("t5_flush_ready", bus.in_ready, 0);
        cycle();
        cycle(); chk("t5_tag0", bus.alloc_tag, 0);

        // rdy low freezes everything and idles the outputs
        set_in(0, 0, 1, 1, 2'b00, 2'b00, 8'hFF);
        repeat (5) cycle();
        chk("t6_en", bus.en, 0); chk("t6_tag", bus.alloc_tag, 15);
        set_in(1, 0, 1, 1, 2'b00, 2'b00, 8'hFF);
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 500) == 0;
            set_in(($urandom % 10) != 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
                   ($urandom % 4) != 0, 2'($urandom % 4 == 0 ? 3 : $urandom % 2),
                   2'($urandom), 8'($urandom));
            cycle();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
